alu_multicycle: RTL

Parametrised-width ALU for the pipeline CPU EX stage that adds iterative unsigned multiply, divide and remainder to the single-cycle integer operations. All results are registered and returned through a start/ready/done handshake. Single-cycle ops complete one clock after acceptance. MUL/DIVU/REMU take WIDTH clocks, and the hazard unit stalls the pipeline on `ready_o`.

---
 rtl/alu_multicycle.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle integer ops plus iterative unsigned MUL/DIVU/REMU.
// Every result is registered and reported with a one-cycle done pulse.
module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int CW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CW-1:0]    ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [CW-1:0] OP_ADD  = CW'(0);
   localparam logic [CW-1:0] OP_SUB  = CW'(1);
   localparam logic [CW-1:0] OP_AND  = CW'(2);
   localparam logic [CW-1:0] OP_OR   = CW'(3);
   localparam logic [CW-1:0] OP_SLT  = CW'(4);
   localparam logic [CW-1:0] OP_SLTU = CW'(5);
   localparam logic [CW-1:0] OP_NOR  = CW'(6);
   localparam logic [CW-1:0] OP_BEQ  = CW'(7);
   localparam logic [CW-1:0] OP_MUL  = CW'(8);
   localparam logic [CW-1:0] OP_DIVU = CW'(9);
   localparam logic [CW-1:0] OP_REMU = CW'(10);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CW-1:0]      op;
   logic [WIDTH-1:0]   opnd;     // multiplicand for MUL, divisor for DIVU/REMU
   logic [2*WIDTH-1:0] prod;     // {partial sum, remaining multiplier bits}
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;

   // single-cycle datapath
   logic [WIDTH-1:0] sc_res;
   logic             sc_zero;
   logic             is_iter;

   always_comb begin
      sc_res  = '0;
      sc_zero = 1'b0;
      is_iter = (ctrl_i == OP_MUL) || (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);
      case (ctrl_i)
         OP_ADD:  sc_res = src1_i + src2_i;
         OP_SUB:  sc_res = src1_i - src2_i;
         OP_AND:  sc_res = src1_i & src2_i;
         OP_OR:   sc_res = src1_i | src2_i;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, src1_i < src2_i};
         OP_NOR:  sc_res = ~(src1_i | src2_i);
         default: sc_res = '0;
      endcase
      if (ctrl_i == OP_BEQ)
         sc_zero = (src1_i == src2_i);
      else if (ctrl_i <= OP_NOR)
         sc_zero = (sc_res == '0);
   end

   // one iteration of shift-add multiply and restoring divide
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_nx;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     rem_nx;
   logic [WIDTH-1:0]   quo_nx;
   logic [WIDTH-1:0]   it_res;

   always_comb begin
      sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      prod_nx = prod[0] ? {sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
      shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
      trial   = shifted - {1'b0, opnd};
      // negative trial means the divisor did not fit: restore
      rem_nx  = trial[WIDTH] ? shifted : trial;
      quo_nx  = {quo[WIDTH-2:0], ~trial[WIDTH]};
      case (op)
         OP_MUL:  it_res = prod_nx[WIDTH-1:0];
         OP_DIVU: it_res = quo_nx;
         OP_REMU: it_res = rem_nx[WIDTH-1:0];
         default: it_res = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         op       <= '0;
         opnd     <= '0;
         prod     <= '0;
         rem      <= '0;
         quo      <= '0;
         ready_o  <= 1'b1;
         done_o   <= 1'b0;
         result_o <= '0;
         zero_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (is_iter) begin
                     op      <= ctrl_i;
                     opnd    <= (ctrl_i == OP_MUL) ? src1_i : src2_i;
                     prod    <= {{WIDTH{1'b0}}, src2_i};
                     rem     <= '0;
                     quo     <= src1_i;
                     cnt     <= CNT_W'(WIDTH);
                     ready_o <= 1'b0;
                     state   <= RUN;
                  end else begin
                     result_o <= sc_res;
                     zero_o   <= sc_zero;
                     done_o   <= 1'b1;
                  end
               end
            end
            RUN: begin
               prod <= prod_nx;
               rem  <= rem_nx;
               quo  <= quo_nx;
               cnt  <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  result_o <= it_res;
                  zero_o   <= (it_res == '0);
                  done_o   <= 1'b1;
                  ready_o  <= 1'b1;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
